axi_lite_arbiter: RTL and testbench
===================================

AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: address width of all AR/AW channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: data width of all R/W channels; WSTRB width is DATA_WIDTH/8.
REQ-003 SHALL have port xdma_axi_aclk, input, 1: single clock for all logic.
REQ-004 SHALL have port xdma_axi_aresetn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have, for n in {0,1}, subordinate ports S<n>_AXI_LITE_{awvalid,awaddr[ADDR_WIDTH],awprot[3]}, input: write address from requester n; awready, output, 1.
REQ-006 SHALL have S<n>_AXI_LITE_{wvalid,wdata[DATA_WIDTH],wstrb[DATA_WIDTH/8]}, input: write data; wready, output, 1.
REQ-007 SHALL have S<n>_AXI_LITE_{bvalid output 1, bresp output 2, bready input 1}: write response.
REQ-008 SHALL have S<n>_AXI_LITE_{arvalid,araddr[ADDR_WIDTH],arprot[3]}, input: read address; arready, output, 1.
REQ-009 SHALL have S<n>_AXI_LITE_{rvalid output 1, rdata output DATA_WIDTH, rresp output 2, rready input 1}: read data.
REQ-010 SHALL have manager port M_AXI_LITE_*: the same five channels with directions mirrored, driving the single shared AXI4-Lite slave.
REQ-011 SHALL have grant, output, 2: one-hot owner of the manager port, or 0 when idle.
REQ-012 SHALL have busy, output, 1: high whenever the state is not IDLE.

Function
REQ-013 SHALL implement the FSM states IDLE, WR_ADDR, WR_RESP, RD_ADDR, and RD_DATA, with exactly one transaction outstanding on M at any time.
REQ-014 SHALL treat requester n as requesting when S<n>_awvalid | S<n>_arvalid, sampled in IDLE.
REQ-015 SHALL arbitrate round-robin: on a single request, grant that requester; on simultaneous requests, grant the requester not granted last.
REQ-016 SHALL give write priority within the granted requester when awvalid and arvalid are both high: go to WR_ADDR, else to RD_ADDR.
REQ-017 SHALL register grant and the state on the IDLE decision edge, so M_*valid rises no earlier than 1 cycle after the request is first seen.
REQ-018 SHALL, in WR_ADDR, pass AW and W combinationally between granted S and M, tracked by independent aw_done/w_done flags.
REQ-019 SHALL, in WR_ADDR, drive M_awvalid = S_awvalid & !aw_done and M_wvalid = S_wvalid & !w_done, with S_awready/S_wready mirroring M readies under the same masks.
REQ-020 SHALL leave WR_ADDR for WR_RESP on the cycle both flags are done, including the case where AW and W complete in the same cycle.
REQ-021 SHALL, in WR_RESP, pass B between granted S and M, and return to IDLE on M_bvalid & S_bready.
REQ-022 SHALL, in RD_ADDR, pass AR; on the AR handshake go to RD_DATA, which passes R and returns to IDLE on M_rvalid & S_rready.
REQ-023 SHALL update last-granted on entry to IDLE after completion, and clear grant to 0 there.
REQ-024 SHALL drive every valid/ready toward the non-granted requester to 0, and its rdata/bresp/rresp to 0.
REQ-025 SHALL drive M_*valid and M_bready/M_rready to 0 in IDLE and in any state not owning that channel; M payloads are don't-care while valid is low.
REQ-026 SHALL keep a pending request from the non-granted requester waiting until the next IDLE cycle, never dropping it.
REQ-027 SHALL pass bresp/rresp unmodified, with no error generation or timeout.
REQ-028 SHALL provide zero-cycle forwarding while granted: handshakes complete on the same edge on both sides.

Reset
REQ-029 SHALL, while xdma_axi_aresetn is low, force state=IDLE, grant=0, busy=0, aw_done=w_done=0, all valid/ready outputs 0, and last-granted=1, so requester 0 wins the first tie.
REQ-030 SHALL, on reset asserted mid-transaction, abandon the transaction immediately and asynchronously; recovery of the external slave is the system's responsibility.
REQ-031 SHALL, after deassertion, accept requests starting on the first rising edge.

Verification
REQ-032 SHALL pass this test: S0 write awaddr=0x10, wdata=0xDEADBEEF, with AW and W in the same cycle, and the slave readies immediately; the required response is M_awaddr=0x10 one cycle after the request, then bresp=0 to S0, with grant=01 and back to 00 after B.
REQ-033 SHALL pass this test: S0 and S1 both assert arvalid from reset; the required response is S0 served first, then S1, then S0 again if it re-requests (alternation verified over 8 transactions).
REQ-034 SHALL pass this test: S1 wvalid 3 cycles after awvalid, with M_awready delayed 2 cycles; the required response is exactly one AW and one W handshake on M, then WR_RESP.
REQ-035 SHALL pass this test: S0 asserts awvalid and arvalid together; the required response is write first, then read on the next grant.
REQ-036 SHALL pass this test: reset asserted in RD_DATA with M_rvalid=0; the required response is all S/M valid/ready at 0 while reset is low, grant=0, and a new S1 read after release completing with rdata=0x12345678.
REQ-037 SHALL pass this test: slave returns rresp=2; the required response is S1_rresp=2 unmodified.

Source files
------------

// File: rtl/axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module : axi_lite_arbiter
// Two-requester round-robin arbiter sharing one AXI4-Lite manager port.
// Rev    : 1.0
// ============================================================================
module axi_lite_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      xdma_axi_aclk,
  input  logic                      xdma_axi_aresetn,
  // requester 0
  input  logic                      S0_AXI_LITE_awvalid,
  input  logic [ADDR_WIDTH-1:0]     S0_AXI_LITE_awaddr,
  input  logic [2:0]                S0_AXI_LITE_awprot,
  output logic                      S0_AXI_LITE_awready,
  input  logic                      S0_AXI_LITE_wvalid,
  input  logic [DATA_WIDTH-1:0]     S0_AXI_LITE_wdata,
  input  logic [DATA_WIDTH/8-1:0]   S0_AXI_LITE_wstrb,
  output logic                      S0_AXI_LITE_wready,
  output logic                      S0_AXI_LITE_bvalid,
  output logic [1:0]                S0_AXI_LITE_bresp,
  input  logic                      S0_AXI_LITE_bready,
  input  logic                      S0_AXI_LITE_arvalid,
  input  logic [ADDR_WIDTH-1:0]     S0_AXI_LITE_araddr,
  input  logic [2:0]                S0_AXI_LITE_arprot,
  output logic                      S0_AXI_LITE_arready,
  output logic                      S0_AXI_LITE_rvalid,
  output logic [DATA_WIDTH-1:0]     S0_AXI_LITE_rdata,
  output logic [1:0]                S0_AXI_LITE_rresp,
  input  logic                      S0_AXI_LITE_rready,
  // requester 1
  input  logic                      S1_AXI_LITE_awvalid,
  input  logic [ADDR_WIDTH-1:0]     S1_AXI_LITE_awaddr,
  input  logic [2:0]                S1_AXI_LITE_awprot,
  output logic                      S1_AXI_LITE_awready,
  input  logic                      S1_AXI_LITE_wvalid,
  input  logic [DATA_WIDTH-1:0]     S1_AXI_LITE_wdata,
  input  logic [DATA_WIDTH/8-1:0]   S1_AXI_LITE_wstrb,
  output logic                      S1_AXI_LITE_wready,
  output logic                      S1_AXI_LITE_bvalid,
  output logic [1:0]                S1_AXI_LITE_bresp,
  input  logic                      S1_AXI_LITE_bready,
  input  logic                      S1_AXI_LITE_arvalid,
  input  logic [ADDR_WIDTH-1:0]     S1_AXI_LITE_araddr,
  input  logic [2:0]                S1_AXI_LITE_arprot,
  output logic                      S1_AXI_LITE_arready,
  output logic                      S1_AXI_LITE_rvalid,
  output logic [DATA_WIDTH-1:0]     S1_AXI_LITE_rdata,
  output logic [1:0]                S1_AXI_LITE_rresp,
  input  logic                      S1_AXI_LITE_rready,
  // shared manager port
  output logic                      M_AXI_LITE_awvalid,
  output logic [ADDR_WIDTH-1:0]     M_AXI_LITE_awaddr,
  output logic [2:0]                M_AXI_LITE_awprot,
  input  logic                      M_AXI_LITE_awready,
  output logic                      M_AXI_LITE_wvalid,
  output logic [DATA_WIDTH-1:0]     M_AXI_LITE_wdata,
  output logic [DATA_WIDTH/8-1:0]   M_AXI_LITE_wstrb,
  input  logic                      M_AXI_LITE_wready,
  input  logic                      M_AXI_LITE_bvalid,
  input  logic [1:0]                M_AXI_LITE_bresp,
  output logic                      M_AXI_LITE_bready,
  output logic                      M_AXI_LITE_arvalid,
  output logic [ADDR_WIDTH-1:0]     M_AXI_LITE_araddr,
  output logic [2:0]                M_AXI_LITE_arprot,
  input  logic                      M_AXI_LITE_arready,
  input  logic                      M_AXI_LITE_rvalid,
  input  logic [DATA_WIDTH-1:0]     M_AXI_LITE_rdata,
  input  logic [1:0]                M_AXI_LITE_rresp,
  output logic                      M_AXI_LITE_rready,
  // status
  output logic [1:0]                grant,
  output logic                      busy
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] grant_q, grant_nxt;
  logic       last_q, last_nxt;
  logic       aw_done, aw_done_nxt;
  logic       w_done, w_done_nxt;

  // requester inputs gathered into index-able vectors
  logic [1:0]                  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [1:0][ADDR_WIDTH-1:0]  s_awaddr, s_araddr;
  logic [1:0][2:0]             s_awprot, s_arprot;
  logic [1:0][DATA_WIDTH-1:0]  s_wdata;
  logic [1:0][STRB_WIDTH-1:0]  s_wstrb;

  assign s_awvalid = {S1_AXI_LITE_awvalid, S0_AXI_LITE_awvalid};
  assign s_wvalid  = {S1_AXI_LITE_wvalid,  S0_AXI_LITE_wvalid};
  assign s_bready  = {S1_AXI_LITE_bready,  S0_AXI_LITE_bready};
  assign s_arvalid = {S1_AXI_LITE_arvalid, S0_AXI_LITE_arvalid};
  assign s_rready  = {S1_AXI_LITE_rready,  S0_AXI_LITE_rready};
  assign s_awaddr  = {S1_AXI_LITE_awaddr,  S0_AXI_LITE_awaddr};
  assign s_araddr  = {S1_AXI_LITE_araddr,  S0_AXI_LITE_araddr};
  assign s_awprot  = {S1_AXI_LITE_awprot,  S0_AXI_LITE_awprot};
  assign s_arprot  = {S1_AXI_LITE_arprot,  S0_AXI_LITE_arprot};
  assign s_wdata   = {S1_AXI_LITE_wdata,   S0_AXI_LITE_wdata};
  assign s_wstrb   = {S1_AXI_LITE_wstrb,   S0_AXI_LITE_wstrb};

  logic [1:0] req;
  logic       pick;
  logic       sel;

  assign req = s_awvalid | s_arvalid;
  // on a tie the requester that was not served last wins
  assign pick = (req == 2'b11) ? ~last_q : req[1];
  assign sel  = grant_q[1];

  // forwarded responses toward the granted requester
  logic                  fwd_awready, fwd_wready, fwd_bvalid, fwd_arready, fwd_rvalid;
  logic [1:0]            fwd_bresp, fwd_rresp;
  logic [DATA_WIDTH-1:0] fwd_rdata;

  always_ff @(posedge xdma_axi_aclk or negedge xdma_axi_aresetn) begin
    if (!xdma_axi_aresetn) begin
      state   <= IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      last_q  <= last_nxt;
      aw_done <= aw_done_nxt;
      w_done  <= w_done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant_q;
    last_nxt    = last_q;
    aw_done_nxt = aw_done;
    w_done_nxt  = w_done;

    M_AXI_LITE_awvalid = 1'b0;
    M_AXI_LITE_wvalid  = 1'b0;
    M_AXI_LITE_bready  = 1'b0;
    M_AXI_LITE_arvalid = 1'b0;
    M_AXI_LITE_rready  = 1'b0;

    fwd_awready = 1'b0;
    fwd_wready  = 1'b0;
    fwd_bvalid  = 1'b0;
    fwd_bresp   = 2'b00;
    fwd_arready = 1'b0;
    fwd_rvalid  = 1'b0;
    fwd_rdata   = '0;
    fwd_rresp   = 2'b00;

    case (state)
      IDLE: begin
        if (|req) begin
          grant_nxt = pick ? 2'b10 : 2'b01;
          state_nxt = s_awvalid[pick] ? WR_ADDR : RD_ADDR;
        end
      end

      WR_ADDR: begin
        M_AXI_LITE_awvalid = s_awvalid[sel] & ~aw_done;
        M_AXI_LITE_wvalid  = s_wvalid[sel] & ~w_done;
        fwd_awready        = M_AXI_LITE_awready & ~aw_done;
        fwd_wready         = M_AXI_LITE_wready & ~w_done;
        aw_done_nxt        = aw_done | (M_AXI_LITE_awvalid & M_AXI_LITE_awready);
        w_done_nxt         = w_done | (M_AXI_LITE_wvalid & M_AXI_LITE_wready);
        if (aw_done_nxt && w_done_nxt) begin
          state_nxt   = WR_RESP;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
        end
      end

      WR_RESP: begin
        M_AXI_LITE_bready = s_bready[sel];
        fwd_bvalid        = M_AXI_LITE_bvalid;
        fwd_bresp         = M_AXI_LITE_bresp;
        if (M_AXI_LITE_bvalid && s_bready[sel]) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          last_nxt  = sel;
        end
      end

      RD_ADDR: begin
        M_AXI_LITE_arvalid = s_arvalid[sel];
        fwd_arready        = M_AXI_LITE_arready;
        if (s_arvalid[sel] && M_AXI_LITE_arready) begin
          state_nxt = RD_DATA;
        end
      end

      RD_DATA: begin
        M_AXI_LITE_rready = s_rready[sel];
        fwd_rvalid        = M_AXI_LITE_rvalid;
        fwd_rdata         = M_AXI_LITE_rdata;
        fwd_rresp         = M_AXI_LITE_rresp;
        if (M_AXI_LITE_rvalid && s_rready[sel]) begin
          state_nxt = IDLE;
          grant_nxt = 2'b00;
          last_nxt  = sel;
        end
      end

      default: begin
        state_nxt = IDLE;
        grant_nxt = 2'b00;
      end
    endcase
  end

  // payloads follow the owner; they only matter while the matching valid is high
  assign M_AXI_LITE_awaddr = s_awaddr[sel];
  assign M_AXI_LITE_awprot = s_awprot[sel];
  assign M_AXI_LITE_wdata  = s_wdata[sel];
  assign M_AXI_LITE_wstrb  = s_wstrb[sel];
  assign M_AXI_LITE_araddr = s_araddr[sel];
  assign M_AXI_LITE_arprot = s_arprot[sel];

  logic [1:0]                 s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0][1:0]            s_bresp, s_rresp;
  logic [1:0][DATA_WIDTH-1:0] s_rdata;

  for (genvar n = 0; n < 2; n++) begin : g_sub
    assign s_awready[n] = grant_q[n] & fwd_awready;
    assign s_wready[n]  = grant_q[n] & fwd_wready;
    assign s_bvalid[n]  = grant_q[n] & fwd_bvalid;
    assign s_arready[n] = grant_q[n] & fwd_arready;
    assign s_rvalid[n]  = grant_q[n] & fwd_rvalid;
    assign s_bresp[n]   = grant_q[n] ? fwd_bresp : 2'b00;
    assign s_rresp[n]   = grant_q[n] ? fwd_rresp : 2'b00;
    assign s_rdata[n]   = grant_q[n] ? fwd_rdata : '0;
  end

  assign S0_AXI_LITE_awready = s_awready[0];
  assign S0_AXI_LITE_wready  = s_wready[0];
  assign S0_AXI_LITE_bvalid  = s_bvalid[0];
  assign S0_AXI_LITE_bresp   = s_bresp[0];
  assign S0_AXI_LITE_arready = s_arready[0];
  assign S0_AXI_LITE_rvalid  = s_rvalid[0];
  assign S0_AXI_LITE_rdata   = s_rdata[0];
  assign S0_AXI_LITE_rresp   = s_rresp[0];

  assign S1_AXI_LITE_awready = s_awready[1];
  assign S1_AXI_LITE_wready  = s_wready[1];
  assign S1_AXI_LITE_bvalid  = s_bvalid[1];
  assign S1_AXI_LITE_bresp   = s_bresp[1];
  assign S1_AXI_LITE_arready = s_arready[1];
  assign S1_AXI_LITE_rvalid  = s_rvalid[1];
  assign S1_AXI_LITE_rdata   = s_rdata[1];
  assign S1_AXI_LITE_rresp   = s_rresp[1];

  assign grant = grant_q;
  assign busy  = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_lite_arbiter
// Directed bench for axi_lite_arbiter with a transaction-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_axi_lite_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // requester-side stimulus
  logic [1:0]        s_awvalid = '0, s_wvalid = '0, s_bready = '0, s_arvalid = '0, s_rready = '0;
  logic [1:0][31:0]  s_awaddr = '0, s_araddr = '0, s_wdata = '0;
  logic [1:0][2:0]   s_awprot = '0, s_arprot = '0;
  logic [1:0][3:0]   s_wstrb = '0;

  logic        s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
  logic        s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
  logic [1:0]  s0_bresp, s0_rresp, s1_bresp, s1_rresp;
  logic [31:0] s0_rdata, s1_rdata;

  logic [1:0]       s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0][1:0]  s_bresp, s_rresp;
  logic [1:0][31:0] s_rdata;
  assign s_awready = {s1_awready, s0_awready};
  assign s_wready  = {s1_wready, s0_wready};
  assign s_bvalid  = {s1_bvalid, s0_bvalid};
  assign s_arready = {s1_arready, s0_arready};
  assign s_rvalid  = {s1_rvalid, s0_rvalid};
  assign s_bresp   = {s1_bresp, s0_bresp};
  assign s_rresp   = {s1_rresp, s0_rresp};
  assign s_rdata   = {s1_rdata, s0_rdata};

  // manager side
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic [31:0] m_awaddr, m_araddr, m_wdata;
  logic [2:0]  m_awprot, m_arprot;
  logic [3:0]  m_wstrb;
  logic        m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
  logic [1:0]  m_bresp = 0, m_rresp = 0;
  logic [31:0] m_rdata = 0;
  logic [1:0]  grant;
  logic        busy;

  axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .xdma_axi_aclk(clk), .xdma_axi_aresetn(rst_n),
    .S0_AXI_LITE_awvalid(s_awvalid[0]), .S0_AXI_LITE_awaddr(s_awaddr[0]), .S0_AXI_LITE_awprot(s_awprot[0]),
    .S0_AXI_LITE_awready(s0_awready), .S0_AXI_LITE_wvalid(s_wvalid[0]), .S0_AXI_LITE_wdata(s_wdata[0]),
    .S0_AXI_LITE_wstrb(s_wstrb[0]), .S0_AXI_LITE_wready(s0_wready), .S0_AXI_LITE_bvalid(s0_bvalid),
    .S0_AXI_LITE_bresp(s0_bresp), .S0_AXI_LITE_bready(s_bready[0]), .S0_AXI_LITE_arvalid(s_arvalid[0]),
    .S0_AXI_LITE_araddr(s_araddr[0]), .S0_AXI_LITE_arprot(s_arprot[0]), .S0_AXI_LITE_arready(s0_arready),
    .S0_AXI_LITE_rvalid(s0_rvalid), .S0_AXI_LITE_rdata(s0_rdata), .S0_AXI_LITE_rresp(s0_rresp),
    .S0_AXI_LITE_rready(s_rready[0]),
    .S1_AXI_LITE_awvalid(s_awvalid[1]), .S1_AXI_LITE_awaddr(s_awaddr[1]), .S1_AXI_LITE_awprot(s_awprot[1]),
    .S1_AXI_LITE_awready(s1_awready), .S1_AXI_LITE_wvalid(s_wvalid[1]), .S1_AXI_LITE_wdata(s_wdata[1]),
    .S1_AXI_LITE_wstrb(s_wstrb[1]), .S1_AXI_LITE_wready(s1_wready), .S1_AXI_LITE_bvalid(s1_bvalid),
    .S1_AXI_LITE_bresp(s1_bresp), .S1_AXI_LITE_bready(s_bready[1]), .S1_AXI_LITE_arvalid(s_arvalid[1]),
    .S1_AXI_LITE_araddr(s_araddr[1]), .S1_AXI_LITE_arprot(s_arprot[1]), .S1_AXI_LITE_arready(s1_arready),
    .S1_AXI_LITE_rvalid(s1_rvalid), .S1_AXI_LITE_rdata(s1_rdata), .S1_AXI_LITE_rresp(s1_rresp),
    .S1_AXI_LITE_rready(s_rready[1]),
    .M_AXI_LITE_awvalid(m_awvalid), .M_AXI_LITE_awaddr(m_awaddr), .M_AXI_LITE_awprot(m_awprot),
    .M_AXI_LITE_awready(m_awready), .M_AXI_LITE_wvalid(m_wvalid), .M_AXI_LITE_wdata(m_wdata),
    .M_AXI_LITE_wstrb(m_wstrb), .M_AXI_LITE_wready(m_wready), .M_AXI_LITE_bvalid(m_bvalid),
    .M_AXI_LITE_bresp(m_bresp), .M_AXI_LITE_bready(m_bready), .M_AXI_LITE_arvalid(m_arvalid),
    .M_AXI_LITE_araddr(m_araddr), .M_AXI_LITE_arprot(m_arprot), .M_AXI_LITE_arready(m_arready),
    .M_AXI_LITE_rvalid(m_rvalid), .M_AXI_LITE_rdata(m_rdata), .M_AXI_LITE_rresp(m_rresp),
    .M_AXI_LITE_rready(m_rready),
    .grant(grant), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  // simple slave: configurable ready/response latencies
  int          aw_lat = 0, w_lat = 0, r_lat = 0;
  logic [31:0] slv_rdata = 32'hA5A5_0000;
  logic [1:0]  slv_rresp = 0, slv_bresp = 0;
  int          n_aw_hs = 0, n_w_hs = 0, n_ar_hs = 0;
  logic [31:0] seen_awaddr = 0, seen_wdata = 0;
  int          aw_cnt = 0, w_cnt = 0, r_cnt = 0;
  bit          got_aw = 0, got_w = 0, rd_pend = 0;

  always @(posedge clk) begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    aw_hs = m_awvalid & m_awready;
    w_hs  = m_wvalid & m_wready;
    b_hs  = m_bvalid & m_bready;
    ar_hs = m_arvalid & m_arready;
    r_hs  = m_rvalid & m_rready;
    if (aw_hs) seen_awaddr = m_awaddr;
    if (w_hs)  seen_wdata  = m_wdata;
    #2;
    if (!rst_n) begin
      got_aw = 0; got_w = 0; rd_pend = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
      m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
    end else begin
      if (aw_hs) begin n_aw_hs++; got_aw = 1; end
      if (w_hs)  begin n_w_hs++;  got_w  = 1; end
      if (b_hs)  m_bvalid = 0;
      if (got_aw && got_w) begin
        m_bvalid = 1; m_bresp = slv_bresp; got_aw = 0; got_w = 0;
      end
      m_awready = m_awvalid && !got_aw && (aw_cnt >= aw_lat);
      aw_cnt    = (m_awvalid && !got_aw) ? aw_cnt + 1 : 0;
      m_wready  = m_wvalid && !got_w && (w_cnt >= w_lat);
      w_cnt     = (m_wvalid && !got_w) ? w_cnt + 1 : 0;
      if (ar_hs) begin n_ar_hs++; rd_pend = 1; r_cnt = 0; end
      if (r_hs)  m_rvalid = 0;
      if (rd_pend) begin
        if (r_cnt >= r_lat) begin
          m_rvalid = 1; m_rdata = slv_rdata; m_rresp = slv_rresp; rd_pend = 0;
        end else r_cnt++;
      end
      m_arready = m_arvalid;
    end
  end

  // reference model: who owns the port and which phase of its transaction is open
  int mdl_own = -1;
  bit mdl_wr, mdl_awd, mdl_wd, mdl_ard;
  bit mdl_last = 1;
  int log_n[$];
  bit log_wr[$];

  always @(negedge clk) begin
    logic       e_awv, e_wv, e_arv, e_bry, e_rry;
    logic [1:0] e_awr, e_wr, e_bv, e_arr, e_rv, rq;
    int         pk;
    bit         done;
    e_awv = 0; e_wv = 0; e_arv = 0; e_bry = 0; e_rry = 0;
    e_awr = 0; e_wr = 0; e_bv = 0; e_arr = 0; e_rv = 0;
    done = 0;
    if (!rst_n) begin
      mdl_own = -1; mdl_last = 1; mdl_awd = 0; mdl_wd = 0; mdl_ard = 0;
    end
    if (mdl_own >= 0) begin
      if (mdl_wr && !(mdl_awd && mdl_wd)) begin
        e_awv = s_awvalid[mdl_own] & !mdl_awd;
        e_wv  = s_wvalid[mdl_own] & !mdl_wd;
        e_awr[mdl_own] = m_awready & !mdl_awd;
        e_wr[mdl_own]  = m_wready & !mdl_wd;
      end else if (mdl_wr) begin
        e_bry = s_bready[mdl_own];
        e_bv[mdl_own] = m_bvalid;
      end else if (!mdl_ard) begin
        e_arv = s_arvalid[mdl_own];
        e_arr[mdl_own] = m_arready;
      end else begin
        e_rry = s_rready[mdl_own];
        e_rv[mdl_own] = m_rvalid;
      end
    end
    chk("grant", 32'(grant), (mdl_own < 0) ? 0 : (1 << mdl_own));
    chk("busy", 32'(busy), 32'(mdl_own >= 0));
    chk("m_awvalid", 32'(m_awvalid), 32'(e_awv));
    chk("m_wvalid", 32'(m_wvalid), 32'(e_wv));
    chk("m_arvalid", 32'(m_arvalid), 32'(e_arv));
    chk("m_bready", 32'(m_bready), 32'(e_bry));
    chk("m_rready", 32'(m_rready), 32'(e_rry));
    chk("s_awready", 32'(s_awready), 32'(e_awr));
    chk("s_wready", 32'(s_wready), 32'(e_wr));
    chk("s_bvalid", 32'(s_bvalid), 32'(e_bv));
    chk("s_arready", 32'(s_arready), 32'(e_arr));
    chk("s_rvalid", 32'(s_rvalid), 32'(e_rv));
    if (m_awvalid && mdl_own >= 0) begin
      chk("m_awaddr", m_awaddr, s_awaddr[mdl_own]);
      chk("m_awprot", 32'(m_awprot), 32'(s_awprot[mdl_own]));
    end
    if (m_wvalid && mdl_own >= 0) begin
      chk("m_wdata", m_wdata, s_wdata[mdl_own]);
      chk("m_wstrb", 32'(m_wstrb), 32'(s_wstrb[mdl_own]));
    end
    if (m_arvalid && mdl_own >= 0) chk("m_araddr", m_araddr, s_araddr[mdl_own]);
    for (int n = 0; n < 2; n++) begin
      if (n != mdl_own) begin
        chk("idle_rdata", s_rdata[n], 0);
        chk("idle_bresp", 32'(s_bresp[n]), 0);
        chk("idle_rresp", 32'(s_rresp[n]), 0);
      end else begin
        if (s_bvalid[n]) chk("s_bresp", 32'(s_bresp[n]), 32'(m_bresp));
        if (s_rvalid[n]) begin
          chk("s_rdata", s_rdata[n], m_rdata);
          chk("s_rresp", 32'(s_rresp[n]), 32'(m_rresp));
        end
      end
    end
    // advance the model to what the coming edge must do
    if (rst_n) begin
      if (mdl_own < 0) begin
        rq = s_awvalid | s_arvalid;
        if (rq != 0) begin
          pk = (rq == 2'b11) ? (mdl_last ? 0 : 1) : (rq[1] ? 1 : 0);
          mdl_own = pk; mdl_wr = s_awvalid[pk];
          mdl_awd = 0; mdl_wd = 0; mdl_ard = 0;
        end
      end else if (mdl_wr && !(mdl_awd && mdl_wd)) begin
        if (m_awvalid && m_awready) mdl_awd = 1;
        if (m_wvalid && m_wready) mdl_wd = 1;
      end else if (mdl_wr) begin
        done = m_bvalid && s_bready[mdl_own];
      end else if (!mdl_ard) begin
        if (m_arvalid && m_arready) mdl_ard = 1;
      end else begin
        done = m_rvalid && s_rready[mdl_own];
      end
      if (done) begin
        log_n.push_back(mdl_own); log_wr.push_back(mdl_wr);
        mdl_last = mdl_own[0]; mdl_own = -1;
      end
    end
  end

  task automatic drop(input int n);
    s_awvalid[n] = 0; s_wvalid[n] = 0; s_bready[n] = 0; s_arvalid[n] = 0; s_rready[n] = 0;
  endtask

  task automatic s_write(input int n, input logic [31:0] addr, input logic [31:0] data, input int w_dly,
                         output logic [1:0] resp, output bit ok);
    int cyc;
    bit awd, wd;
    ok = 0; resp = 0; awd = 0; wd = 0; cyc = 0;
    s_awaddr[n] = addr; s_awprot[n] = 3'd2; s_wdata[n] = data; s_wstrb[n] = 4'hF;
    s_awvalid[n] = 1; s_wvalid[n] = (w_dly == 0);
    while (!(awd && wd)) begin
      @(posedge clk);
      if (!rst_n) begin drop(n); return; end
      if (s_awvalid[n] && s_awready[n]) awd = 1;
      if (s_wvalid[n] && s_wready[n]) wd = 1;
      #1; cyc++;
      if (awd) s_awvalid[n] = 0;
      if (wd) s_wvalid[n] = 0; else if (cyc >= w_dly) s_wvalid[n] = 1;
      if (cyc > 200) begin timeout_fail("write_addr"); drop(n); return; end
    end
    s_bready[n] = 1;
    cyc = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin drop(n); return; end
      if (s_bvalid[n]) begin resp = s_bresp[n]; break; end
      if (++cyc > 200) begin timeout_fail("write_resp"); drop(n); return; end
    end
    #1; s_bready[n] = 0; ok = 1;
  endtask

  task automatic s_read(input int n, input logic [31:0] addr, output logic [31:0] data,
                        output logic [1:0] resp, output bit ok);
    int cyc;
    ok = 0; data = 0; resp = 0; cyc = 0;
    s_araddr[n] = addr; s_arprot[n] = 3'd1; s_arvalid[n] = 1;
    forever begin
      @(posedge clk);
      if (!rst_n) begin drop(n); return; end
      if (s_arvalid[n] && s_arready[n]) break;
      if (++cyc > 200) begin timeout_fail("read_addr"); drop(n); return; end
    end
    #1; s_arvalid[n] = 0; s_rready[n] = 1; cyc = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin drop(n); return; end
      if (s_rvalid[n]) begin data = s_rdata[n]; resp = s_rresp[n]; break; end
      if (++cyc > 200) begin timeout_fail("read_data"); drop(n); return; end
    end
    #1; s_rready[n] = 0; ok = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  rs, rs0, rs1;
    logic [31:0] rd, rd0, rd1;
    bit          ok, ok0, ok1;
    int          base, na, nw, g;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1;

    // single S0 write, AW and W together, slave ready at once
    fork
      s_write(0, 32'h10, 32'hDEAD_BEEF, 0, rs, ok);
      begin
        @(posedge clk); #1;
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_awvalid", 32'(m_awvalid), 1);
        chk("t1_awaddr", m_awaddr, 32'h10);
        chk("t1_wdata", m_wdata, 32'hDEAD_BEEF);
      end
    join
    chk("t1_ok", 32'(ok), 1);
    chk("t1_bresp", 32'(rs), 0);
    chk("t1_grant_after", 32'(grant), 0);
    chk("t1_slave_data", seen_wdata, 32'hDEAD_BEEF);

    // fresh reset, then both requesters read continuously: strict alternation from S0
    @(posedge clk); #1; rst_n = 0;
    repeat (2) @(posedge clk); #1; rst_n = 1;
    base = log_n.size();
    fork
      repeat (4) begin s_read(0, 32'h100, rd0, rs0, ok0); chk("t2_rd0", rd0, 32'hA5A5_0000); end
      repeat (4) begin s_read(1, 32'h200, rd1, rs1, ok1); chk("t2_rd1", rd1, 32'hA5A5_0000); end
    join
    chk("t2_count", 32'(log_n.size() - base), 8);
    for (int i = 0; i < 8; i++)
      if (base + i < log_n.size()) chk("t2_order", 32'(log_n[base+i]), 32'(i % 2));

    // S1 write with W lagging AW by 3 cycles and AW ready delayed 2 cycles
    aw_lat = 2; na = n_aw_hs; nw = n_w_hs; base = log_n.size();
    s_write(1, 32'h20, 32'hCAFE_F00D, 3, rs, ok);
    aw_lat = 0;
    chk("t3_ok", 32'(ok), 1);
    chk("t3_aw_hs", 32'(n_aw_hs - na), 1);
    chk("t3_w_hs", 32'(n_w_hs - nw), 1);
    chk("t3_addr", seen_awaddr, 32'h20);
    if (log_n.size() > base) chk("t3_owner", 32'(log_n[base]), 1);

    // S0 asks for write and read together: write first, then the read
    base = log_n.size();
    slv_bresp = 2'd1;
    fork
      s_write(0, 32'h30, 32'h0000_1234, 0, rs0, ok0);
      s_read(0, 32'h34, rd0, rs1, ok1);
    join
    slv_bresp = 2'd0;
    chk("t4_bresp", 32'(rs0), 1);
    chk("t4_count", 32'(log_n.size() - base), 2);
    if (log_n.size() >= base + 2) begin
      chk("t4_first_is_write", 32'(log_wr[base]), 1);
      chk("t4_second_is_read", 32'(log_wr[base+1]), 0);
    end

    // error response passes through untouched
    slv_rresp = 2'd2;
    s_read(1, 32'h40, rd, rs, ok);
    slv_rresp = 2'd0;
    chk("t5_ok", 32'(ok), 1);
    chk("t5_rresp", 32'(rs), 2);

    // reset while S0 sits in the read-data phase
    r_lat = 50; na = n_ar_hs;
    fork
      s_read(0, 32'h50, rd0, rs0, ok0);
      begin
        g = 0;
        while (n_ar_hs == na && g < 100) begin @(posedge clk); g++; end
        if (g >= 100) timeout_fail("t6_wait_ar");
        repeat (3) @(posedge clk);
        #3; rst_n = 0;
        #1;
        chk("t6_grant", 32'(grant), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_m_valids", 32'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 0);
        chk("t6_s_readys", 32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid}), 0);
        repeat (3) @(posedge clk);
        #3; rst_n = 1;
      end
    join
    chk("t6_aborted", 32'(ok0), 0);
    r_lat = 0; slv_rdata = 32'h1234_5678;
    s_read(1, 32'h60, rd, rs, ok);
    chk("t6_ok", 32'(ok), 1);
    chk("t6_rdata", rd, 32'h1234_5678);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
